// File: rtl/udm_bus_arb_pkg.sv
// Shared types and constants for the two-master round-robin bus arbiter.
package udm_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CMD  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEADBEEF;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/udm_bus_arb_rr_arb2.sv
// Combinational two-way round-robin pick; one-hot grant, the master that was
// not granted last wins a conflict.
module rr_arb2
  import udm_bus_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_i == ARB_M1) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/udm_bus_arb.sv
// Two-master, one-slave round-robin bus arbiter with grant lock per transaction.
// Optional slave watchdog enabled by defining UDM_BUS_ARB_TIMEOUT_EN.
module udm_bus_arb
  import udm_bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,
  output logic [1:0]  grant_bo,
  output logic        timeout_o
);

  arb_state_t  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic [1:0]  pick;
  logic        owner, sel_we, bus_on;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        ack, resp, fire, to_hit;
  logic [31:0] rdata;

  rr_arb2 u_rr (
    .req_i        ({m1_req_i, m0_req_i}),
    .last_grant_i (last_q),
    .gnt_o        (pick)
  );

  assign owner     = grant_q[1] ? ARB_M1 : ARB_M0;
  assign sel_we    = (owner == ARB_M1) ? m1_we_i     : m0_we_i;
  assign sel_addr  = (owner == ARB_M1) ? m1_addr_bi  : m0_addr_bi;
  assign sel_be    = (owner == ARB_M1) ? m1_be_bi    : m0_be_bi;
  assign sel_wdata = (owner == ARB_M1) ? m1_wdata_bi : m0_wdata_bi;

  // Slave command is only driven while the owner's command is in flight.
  assign bus_on     = (state_q == ARB_CMD) && rstn_i;
  assign s_req_o    = bus_on;
  assign s_we_o     = bus_on && sel_we;
  assign s_addr_bo  = bus_on ? sel_addr  : '0;
  assign s_be_bo    = bus_on ? sel_be    : '0;
  assign s_wdata_bo = bus_on ? sel_wdata : '0;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack     = 1'b0;
    resp    = 1'b0;
    fire    = 1'b0;
    rdata   = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick != 2'b00) begin
          grant_d = pick;
          last_d  = pick[1] ? ARB_M1 : ARB_M0;
          state_d = ARB_CMD;
        end
      end
      ARB_CMD: begin
        if (s_ack_i) begin
          ack     = 1'b1;
          state_d = ARB_IDLE;
          if (!sel_we) begin
            if (s_resp_i) begin
              resp  = 1'b1;
              rdata = s_rdata_bi;
            end else begin
              state_d = ARB_RESP;
            end
          end
        end else if (to_hit) begin
          fire    = 1'b1;
          ack     = 1'b1;
          resp    = !sel_we;
          rdata   = sel_we ? '0 : ARB_TIMEOUT_RDATA;
          state_d = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        if (s_resp_i) begin
          resp    = 1'b1;
          rdata   = s_rdata_bi;
          state_d = ARB_IDLE;
        end else if (to_hit) begin
          fire    = 1'b1;
          resp    = 1'b1;
          rdata   = ARB_TIMEOUT_RDATA;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (state_q != ARB_IDLE && state_d == ARB_IDLE) grant_d = 2'b00;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ARB_IDLE;
      grant_q <= 2'b00;
      last_q  <= ARB_M1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Reset low abandons the transaction in the same cycle: nothing is forwarded.
  assign m0_ack_o    = ack  && rstn_i && (owner == ARB_M0);
  assign m1_ack_o    = ack  && rstn_i && (owner == ARB_M1);
  assign m0_resp_o   = resp && rstn_i && (owner == ARB_M0);
  assign m1_resp_o   = resp && rstn_i && (owner == ARB_M1);
  assign m0_rdata_bo = m0_resp_o ? rdata : '0;
  assign m1_rdata_bo = m1_resp_o ? rdata : '0;
  assign grant_bo    = grant_q;

`ifdef UDM_BUS_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Restarts on every entry into CMD or RESP.
  always_comb begin
    cnt_d = '0;
    if (state_q != ARB_IDLE && state_d == state_q) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign to_hit    = (state_q != ARB_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = fire && rstn_i;
`else
  assign to_hit    = 1'b0;
  assign timeout_o = fire && (TIMEOUT_CYCLES != 0) && 1'b0;
`endif

endmodule

// File: doc/udm_bus_arb.md
# udm_bus_arb

Two-master, one-slave round-robin arbiter that shares the on-board bus (CSR block at 0x0000_0000 for LED/SW, test memory at 0x8000_0000) between the UART debug master `udm` (master 0) and a second on-chip requester (master 1, e.g. a CPU core or DMA). It sits in `NEXYS4_DDR` between the masters' req/ack/resp bus ports and the address decoder. It serialises transactions and locks the grant until each transaction completes. An optional watchdog releases the bus if the slave hangs.

## Interface
- `TIMEOUT_CYCLES`, default 256: watchdog limit in cycles. Used only when `UDM_BUS_ARB_TIMEOUT_EN` is defined.
- `clk_i` in 1: system clock.
- `rstn_i` in 1: synchronous, active-low reset.
- `m0_req_i` in 1: master 0 request; held stable until `m0_ack_o`.
- `m0_we_i` in 1: 1 = write, 0 = read.
- `m0_addr_bi` in 32: byte address.
- `m0_be_bi` in 4: byte enables.
- `m0_wdata_bi` in 32: write data.
- `m0_ack_o` out 1: command accepted (1-cycle pulse).
- `m0_resp_o` out 1: read data valid (1-cycle pulse).
- `m0_rdata_bo` out 32: read data, valid with `m0_resp_o`.
- `m1_req_i`, `m1_we_i`, `m1_addr_bi`, `m1_be_bi`, `m1_wdata_bi`, `m1_ack_o`, `m1_resp_o`, `m1_rdata_bo`: same set and widths as master 0, for master 1.
- `s_req_o` out 1: slave request.
- `s_we_o` out 1: slave write enable.
- `s_addr_bo` out 32: slave address.
- `s_be_bo` out 4: slave byte enables.
- `s_wdata_bo` out 32: slave write data.
- `s_ack_i` in 1: slave accepted command.
- `s_resp_i` in 1: slave read data valid.
- `s_rdata_bi` in 32: slave read data.
- `grant_bo` out 2: one-hot current owner; 00 when idle.
- `timeout_o` out 1: 1-cycle pulse when the watchdog fires.

## Operation
- FSM states: IDLE, CMD, RESP.
- **IDLE:**
  - Only one request: grant it.
  - Both requesting: grant the master that was not `last_grant`.
  - On a grant, register the owner into `grant_bo` and `last_grant`, then go to CMD.
- **CMD:**
  - `s_*` outputs mux the owner's command combinationally; `s_req_o` = 1.
  - `s_ack_i` is forwarded to the owner's `ack` in the same cycle.
  - On ack with a write: go to IDLE.
  - On ack with a read and `s_resp_i` also high in that cycle: forward `resp`/`rdata` and go to IDLE.
  - On ack with a read otherwise: go to RESP.
- **RESP:**
  - `s_req_o` = 0.
  - Wait for `s_resp_i`, forward `resp`/`rdata` to the owner, go to IDLE.
- Non-owner `ack`, `resp` and `rdata` are always 0.
- `s_ack_i` or `s_resp_i` arriving in IDLE, or `s_resp_i` arriving in CMD for a write, is ignored.
- Master 1 has no priority over master 0 except by round-robin alternation. Neither master can be granted twice in a row while the other is requesting.

## Timing
- **Reset values:** state IDLE; `grant_bo` = 00; `last_grant` = master 1 (so master 0 wins the first conflict); `s_req_o` = 0; `timeout_o` = 0; all `ack`/`resp` = 0; all data and address outputs = 0.
- **Request to bus:** `req` sampled high in IDLE at cycle N gives `s_req_o` = 1 at cycle N+1.
- **Write:** completes in the cycle of `s_ack_i`.
- **Read:** completes in the cycle of `s_resp_i`.
- **Turnaround:** one IDLE cycle always separates consecutive transactions.
- **Reset mid-transaction:** abandon immediately; no `ack`/`resp` to any master. A late slave `resp` arriving after reset is dropped in IDLE.
- **Simultaneous requests at cycle N:** exactly one grant at N+1. The loser keeps its `req` high and is granted on the next IDLE evaluation.

## Configuration
- **`UDM_BUS_ARB_TIMEOUT_EN` defined:** a counter clears on entry to CMD/RESP and increments each cycle in those states. When it reaches `TIMEOUT_CYCLES`-1 without completion:
  - `timeout_o` pulses for 1 cycle.
  - In CMD: pulse the owner's `ack`, and also `resp` with `rdata` = 32'hDEADBEEF if the transaction is a read.
  - In RESP: pulse `resp` with 32'hDEADBEEF.
  - `s_req_o` drops and the state goes to IDLE.
- **Undefined:** no counter; `timeout_o` is tied 0; a hung slave stalls the bus indefinitely.

## Structure
- Package `udm_bus_arb_pkg`: FSM state enum `arb_state_t`, `ARB_TIMEOUT_RDATA` = 32'hDEADBEEF, master index constants `ARB_M0` and `ARB_M1`.
- One sub-module `rr_arb2`: combinational 2-way round-robin pick from `req[1:0]` and `last_grant`, with one-hot output.

## Test plan
- **Single write:** m0 write 0x8000_0000 ← 0x112233CC; slave acks 2 cycles after `s_req_o` → `m0_ack_o` pulses once; `s_wdata_bo` = 0x112233CC; `grant_bo` 01 → 00.
- **Read with latency:** m1 read 0x0000_0004; slave acks at once, `resp` 3 cycles later with 0x0000_0030 → `m1_rdata_bo` = 0x30 with `m1_resp_o`; `m0_*` outputs stay 0.
- **Contention:** both request in the same cycle after reset → m0 granted first, m1 next. Both hold `req` continuously → grants alternate 01, 10, 01, with 1 IDLE cycle between each.
- **Zero-latency read:** `s_ack_i` and `s_resp_i` high in the same cycle for a read of 0x8000_0024 (returning 0xDEADBEEF from memory) → single-cycle completion, no RESP state.
- **Reset mid-read:** `rstn_i` = 0 while in RESP; slave `resp` arrives afterwards → no master `resp`; all outputs at reset values.
- **Timeout (macro on, `TIMEOUT_CYCLES` = 16):** read with the slave never responding → `timeout_o` and `m0_resp_o` pulse at cycle 16 with `rdata` 0xDEADBEEF; the next m1 request is served normally.
